// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo decoder front-end: state encoding
// and the rotate-priority pick used by the packet arbiters.
package turbo_pkg;

  localparam int TRB_DW  = 12;
  localparam int TRB_BLK = 1024;
  localparam int RR_MAX  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Search starts one past ptr and wraps modulo n; the first set mask bit wins.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] mask,
                                       input logic [1:0]        ptr,
                                       input int                n);
    rr_pick_t   r;
    int         idx;
    logic [1:0] i2;
    r.found = 1'b0;
    r.idx   = 2'd0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        i2  = 2'(idx);
        if (!r.found && mask[i2]) begin
          r.found = 1'b1;
          r.idx   = i2;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational rotate-priority encoder: picks the first requester after ptr.
module rr_arbiter_comb
  import turbo_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               found
);

  rr_pick_t pick;

  always_comb begin
    pick   = rr_pick(RR_MAX'(req), 2'(ptr), NUM_REQ);
    winner = IDW'(pick.idx);
    found  = pick.found;
  end

endmodule

// File: rtl/turbo_pkt_arb.sv
// Packet-level round-robin arbiter and credit controller sharing one turbo
// decoder sink between NUM_REQ streaming sources.
module turbo_pkt_arb
  import turbo_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DW           = TRB_DW,
  parameter int MAX_INFLIGHT = 2,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_sop,
  input  logic [NUM_REQ-1:0]    req_eop,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  trb_sink_valid,
  output logic                  trb_sink_sop,
  output logic                  trb_sink_eop,
  output logic [DW-1:0]         trb_sink_data,
  input  logic                  trb_sink_ready,
  input  logic                  trb_source_eop,
  output logic [IDW-1:0]        grant_id,
  output logic [2:0]            inflight,
  output logic                  busy,
  output logic                  sop_err
);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      grant_q;
  logic [2:0]          inflight_q;
  logic [IDW-1:0]      winner;
  logic                found;
  logic                credit_ok;
  logic                grant_now;
  logic                acc_eop;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  flush_cand;
  logic [NUM_REQ-1:0]  flush_sel;

  // Saturating packet-occupancy update; simultaneous in/out leaves it unchanged.
  function automatic logic [2:0] next_inflight(input logic [2:0] cur,
                                               input logic       inc,
                                               input logic       dec);
    case ({inc, dec})
      2'b10:   return cur + 3'd1;
      2'b01:   return (cur == 3'd0) ? cur : cur - 3'd1;
      default: return cur;
    endcase
  endfunction

  assign credit_ok  = (inflight_q < 3'(MAX_INFLIGHT));
  assign elig       = (state_q == IDLE && credit_ok) ? (req_valid & req_sop) : '0;
  assign grant_now  = (state_q == IDLE) && found;
  assign flush_cand = req_valid & ~req_sop;
  assign flush_sel  = flush_cand & (~flush_cand + NUM_REQ'(1));

  rr_arbiter_comb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req    (elig),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    state_d        = state_q;
    req_ready      = '0;
    trb_sink_valid = 1'b0;
    trb_sink_sop   = 1'b0;
    trb_sink_eop   = 1'b0;
    trb_sink_data  = '0;
    sop_err        = 1'b0;
    acc_eop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          state_d = LOCK;
        end else if (|flush_cand) begin
          // Headless beats are drained one requester per cycle, lowest index first.
          req_ready = flush_sel;
          sop_err   = 1'b1;
        end
      end
      LOCK: begin
        trb_sink_valid     = req_valid[grant_q];
        trb_sink_sop       = req_sop[grant_q];
        trb_sink_eop       = req_eop[grant_q];
        trb_sink_data      = req_data[grant_q*DW +: DW];
        req_ready[grant_q] = trb_sink_ready;
        if (req_valid[grant_q] && trb_sink_ready && req_eop[grant_q]) begin
          acc_eop = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs must read idle while reset is held, even with live inputs.
    if (!rst_n) begin
      req_ready      = '0;
      trb_sink_valid = 1'b0;
      trb_sink_sop   = 1'b0;
      trb_sink_eop   = 1'b0;
      trb_sink_data  = '0;
      sop_err        = 1'b0;
      acc_eop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      inflight_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= next_inflight(inflight_q, acc_eop, trb_source_eop);
      if (grant_now) begin
        grant_q  <= winner;
        rr_ptr_q <= winner;
      end
    end
  end

  assign grant_id = grant_q;
  assign inflight = inflight_q;
  assign busy     = (state_q != IDLE) || (inflight_q != 3'd0);

endmodule

// File: doc/turbo_pkt_arb.md
Name: turbo_pkt_arb

Overview:
Packet-level round-robin arbiter and credit controller that shares one turbo_d0 decoder instance between NUM_REQ bus2st_sync streaming sources, all in the clk_st domain. It grants the decoder sink to one requester per turbo packet (sop..eop) and never splits a packet. It limits the number of packets inside the decoder to MAX_INFLIGHT, so that the per-packet sink_ready gating is done centrally. It also discards malformed leading beats and flags them.

Parameters:
NUM_REQ, 2, number of requesting streams (2..4)
DW, 12, sink data width per beat
MAX_INFLIGHT, 2, maximum packets accepted by the decoder whose source_eop has not yet been seen (1..7)
IDW, 1, requester index width, $clog2(NUM_REQ)

Ports:
clk  in  1  decoder clock (clk_st domain)
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_sop  in  NUM_REQ  per-requester start of packet
req_eop  in  NUM_REQ  per-requester end of packet
req_data  in  NUM_REQ*DW  concatenated beat data, requester i at [i*DW +: DW]
req_ready  out  NUM_REQ  per-requester ready
trb_sink_valid  out  1  to decoder sink_valid
trb_sink_sop  out  1  to decoder sink_sop
trb_sink_eop  out  1  to decoder sink_eop
trb_sink_data  out  DW  to decoder sink_data
trb_sink_ready  in  1  from decoder sink_ready
trb_source_eop  in  1  decoder output packet complete (source_valid & source_ready & source_eop)
grant_id  out  IDW  current or last owner
inflight  out  3  packets currently inside the decoder
busy  out  1  high when state is not IDLE or inflight is nonzero
sop_err  out  1  one-cycle pulse when a beat without sop is flushed

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state = IDLE; rr_ptr = 0; grant_id = 0; inflight = 0.
  - All req_ready = 0; trb_sink_valid/sop/eop = 0; trb_sink_data = 0; sop_err = 0; busy = 0.
- States:
  - IDLE: no owner.
  - LOCK: an owner is streaming.
- IDLE arbitration:
  - Eligible requester: req_valid & req_sop.
  - An eligible requester is granted only if inflight < MAX_INFLIGHT.
  - Search order starts at rr_ptr+1 and wraps modulo NUM_REQ. The first eligible requester wins.
  - On a win: grant_id <= winner, rr_ptr <= winner, state <= LOCK.
  - Grant is registered. The request is seen in cycle N and the first beat passes in cycle N+1, which gives 1 cycle of arbitration latency per packet.
- IDLE flush:
  - Applies to a requester with req_valid=1 and req_sop=0 when no grant is issued that cycle.
  - That requester alone gets req_ready=1 and the beat is dropped.
  - sop_err pulses in the same cycle.
  - When several requesters qualify, only the lowest index is flushed per cycle.
- LOCK:
  - Combinational passthrough from owner o:
    - trb_sink_valid = req_valid[o]; trb_sink_sop = req_sop[o]; trb_sink_eop = req_eop[o]; trb_sink_data = req_data[o].
    - req_ready[o] = trb_sink_ready. All other req_ready = 0.
  - Accepted beat = trb_sink_valid & trb_sink_ready.
  - An accepted beat with eop moves state to IDLE in the next cycle. Back-to-back packets therefore have a 1-cycle bubble.
  - A sop on a non-first beat is passed through unchanged; the decoder flags it.
- Outputs outside LOCK: trb_sink_valid/sop/eop = 0 and trb_sink_data = 0.
- inflight counter:
  - +1 on an accepted eop beat.
  - −1 on trb_source_eop.
  - Both in the same cycle: unchanged.
  - Saturates at 0 on a spurious source_eop; never exceeds MAX_INFLIGHT by construction.
- Credit stall: when inflight == MAX_INFLIGHT, IDLE stays in IDLE. A requester with sop waits with req_ready=0 and is not flushed.
- Single requester: it is re-granted every packet. rr_ptr still updates.
- Reset mid-packet: everything returns to IDLE immediately. Partial packets are the upstream's and decoder's problem; the decoder reset shares rst_n.

Decomposition:
- Shared package turbo_pkg:
  - Constants TRB_DW=12 and TRB_BLK=1024.
  - State enum {IDLE, LOCK}.
  - Function rr_pick(mask, ptr) returning the winner index and a found flag.
- One sub-module, rr_arbiter_comb: pure combinational rotate-priority encoder with inputs req mask and rr_ptr, outputs winner and found. It is reused by future multi-decoder schedulers.

Test Plan:
- Single packet: req0 sends 1028 beats sop..eop with trb_sink_ready=1 -> grant_id=0, first beat on trb_sink 1 cycle after req0 sop, inflight=1 after eop, req1 ready never high.
- Round-robin: req0 and req1 both hold sop continuously, MAX_INFLIGHT=7, trb_source_eop pulsed after each packet -> grant order 1,0,1,0 starting from rr_ptr=0, 1-cycle bubble between packets.
- Credit stall: MAX_INFLIGHT=2, no trb_source_eop -> after 2 packets inflight=2 and busy=1, req0 sop held with req_ready=0. A trb_source_eop pulse leads to a grant 1 cycle later.
- Simultaneous events: accepted eop in the same cycle as trb_source_eop with inflight=1 -> inflight stays 1.
- Malformed beat: req1 valid with sop=0 in IDLE -> req_ready[1]=1 for one cycle, sop_err pulses, trb_sink_valid stays 0. The following sop beat is granted normally.
- Backpressure and reset: trb_sink_ready toggled 1010 during LOCK -> req_ready[o] mirrors it, no beats lost or duplicated (beat count equals 1028). rst_n asserted mid-packet -> all outputs reach reset values asynchronously, inflight=0.
